// File: rtl/conv_window_loader_if.sv
// Sample stream into the convolution window loader: valid/ready handshake carrying one
// PIX_W-bit weight or pixel per transfer.
interface conv_window_loader_if #(
    parameter int unsigned PIX_W = 2
) ();
    logic             s_valid;
    logic             s_ready;
    logic [PIX_W-1:0] s_data;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/conv_window_loader.sv
// Packs a serial stream of K*K filter weights followed by IMG*IMG pixels into flat words for the
// 3x3 convolution array. Optional sticky overflow flag ovf_o is enabled by CONV_LOADER_OVF_EN.
module conv_window_loader #(
    parameter int unsigned PIX_W       = 2,
    parameter int unsigned IMG         = 5,
    parameter int unsigned K           = 3,
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    conv_window_loader_if.slave        s,
    input  logic                       filt_reload_i,
    output logic [IMG*IMG*PIX_W-1:0]   win_data_o,
    output logic [K*K*PIX_W-1:0]       filt_data_o,
    output logic                       win_valid_o,
`ifdef CONV_LOADER_OVF_EN
    output logic                       ovf_o,
`endif
    output logic                       busy_o
);

    localparam int unsigned NWin   = IMG * IMG;
    localparam int unsigned NFilt  = K * K;
    localparam int unsigned WinW   = NWin * PIX_W;
    localparam int unsigned FiltW  = NFilt * PIX_W;
    localparam int unsigned CntMax = (NWin > HOLD_CYCLES) ? NWin : HOLD_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    typedef enum logic [1:0] {StIdle, StLoadF, StLoadP, StHold} state_e;

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic [FiltW-1:0]  filt_shadow_q, filt_data_q, filt_merged;
    logic [WinW-1:0]   win_shadow_q, win_data_q, win_merged;
    logic              win_valid_q;
    logic              s_ready_q;
    logic              busy_q;
    logic              xfer;
`ifdef CONV_LOADER_OVF_EN
    logic              ovf_q;
`endif

    assign xfer = s.s_valid && s_ready_q;

    // Shadow with the current sample merged in, so the final transfer publishes a complete word.
    always_comb begin
        filt_merged = filt_shadow_q;
        win_merged  = win_shadow_q;
        filt_merged[cnt_q*PIX_W +: PIX_W] = s.s_data;
        win_merged[cnt_q*PIX_W +: PIX_W]  = s.s_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            filt_shadow_q <= '0;
            win_shadow_q  <= '0;
            filt_data_q   <= '0;
            win_data_q    <= '0;
            win_valid_q   <= 1'b0;
            s_ready_q     <= 1'b0;
            busy_q        <= 1'b0;
`ifdef CONV_LOADER_OVF_EN
            ovf_q         <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_q   <= StLoadF;
                    s_ready_q <= 1'b1;
                    busy_q    <= 1'b1;
                end
                StLoadF: begin
                    if (xfer) begin
                        filt_shadow_q <= filt_merged;
                        if (cnt_q == CntW'(NFilt - 1)) begin
                            filt_data_q <= filt_merged;
                            cnt_q       <= '0;
                            state_q     <= StLoadP;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                StLoadP: begin
                    if (xfer) begin
                        win_shadow_q <= win_merged;
                        if (cnt_q == CntW'(NWin - 1)) begin
                            win_data_q <= win_merged;
                            cnt_q      <= '0;
                            s_ready_q  <= 1'b0;
                            state_q    <= StHold;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                StHold: begin
                    // First HOLD cycle exposes the window; win_valid follows one cycle later.
                    if (cnt_q == CntW'(HOLD_CYCLES)) begin
                        cnt_q       <= '0;
                        win_valid_q <= 1'b0;
                        s_ready_q   <= 1'b1;
                        state_q     <= filt_reload_i ? StLoadF : StLoadP;
                    end else begin
                        cnt_q       <= cnt_q + 1'b1;
                        win_valid_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
`ifdef CONV_LOADER_OVF_EN
            ovf_q <= ovf_q | (s.s_valid & ~s_ready_q);
`endif
        end
    end

    assign s.s_ready   = s_ready_q;
    assign win_data_o  = win_data_q;
    assign filt_data_o = filt_data_q;
    assign win_valid_o = win_valid_q;
    assign busy_o      = busy_q;
`ifdef CONV_LOADER_OVF_EN
    assign ovf_o       = ovf_q;
`endif

endmodule

// File: tb/tb_conv_window_loader.sv
// Directed bench for conv_window_loader: filter/window packing, HOLD timing, reload and reset.
module tb_conv_window_loader;

    logic        clk;
    logic        rst_n;
    logic        filt_reload;
    logic [49:0] win_data;
    logic [17:0] filt_data;
    logic        win_valid;
    logic        busy;
`ifdef CONV_LOADER_OVF_EN
    logic        ovf;
`endif
    int          checks;
    int          errors;

    conv_window_loader_if #(.PIX_W(2)) s_if ();

    conv_window_loader dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s             (s_if),
        .filt_reload_i (filt_reload),
        .win_data_o    (win_data),
        .filt_data_o   (filt_data),
        .win_valid_o   (win_valid),
`ifdef CONV_LOADER_OVF_EN
        .ovf_o         (ovf),
`endif
        .busy_o        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One accepted sample; the loader must be ready in the cycle it is offered.
    task automatic xfer(input logic [1:0] d);
        s_if.s_valid = 1'b1;
        s_if.s_data  = d;
        chk("xfer_ready", 64'(s_if.s_ready), 64'd1);
        tick();
        s_if.s_valid = 1'b0;
    endtask

    // Entered on the cycle after the last pixel transfer.
    task automatic check_hold(input logic reload, input logic poke, input logic [63:0] exp_win);
        chk("hold_entry_valid", 64'(win_valid), 64'd0);
        chk("hold_entry_ready", 64'(s_if.s_ready), 64'd0);
        chk("hold_entry_win", 64'(win_data), exp_win);
        filt_reload = ~reload;
        for (int c = 0; c < 4; c++) begin
            tick();
            s_if.s_valid = poke && (c == 0);
            s_if.s_data  = 2'd2;
            if (c == 3) filt_reload = reload;
            chk("hold_valid", 64'(win_valid), 64'd1);
            chk("hold_ready", 64'(s_if.s_ready), 64'd0);
            chk("hold_win", 64'(win_data), exp_win);
        end
        tick();
        filt_reload = 1'b0;
        chk("post_hold_valid", 64'(win_valid), 64'd0);
        chk("post_hold_ready", 64'(s_if.s_ready), 64'd1);
        chk("post_hold_win", 64'(win_data), exp_win);
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst_n          = 1'b0;
        filt_reload    = 1'b0;
        s_if.s_valid   = 1'b0;
        s_if.s_data    = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_win", 64'(win_data), 64'd0);
        chk("rst_filt", 64'(filt_data), 64'd0);
        chk("rst_valid", 64'(win_valid), 64'd0);
        chk("rst_ready", 64'(s_if.s_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
`ifdef CONV_LOADER_OVF_EN
        chk("rst_ovf", 64'(ovf), 64'd0);
`endif
        rst_n = 1'b1;
        chk("idle_busy", 64'(busy), 64'd0);
        tick();
        chk("loadf_ready", 64'(s_if.s_ready), 64'd1);
        chk("loadf_busy", 64'(busy), 64'd1);

        // Weights 0,1,2,3,0,1,2,3,0
        for (int i = 0; i < 9; i++) begin
            if (i == 8) chk("filt_before_last", 64'(filt_data), 64'd0);
            xfer(2'(i % 4));
        end
        chk("filt1", 64'(filt_data), 64'h0E4E4);
        chk("loadp_ready", 64'(s_if.s_ready), 64'd1);

        // Tile 1: all 3
        for (int i = 0; i < 25; i++) begin
            if (i == 24) chk("win_before_last", 64'(win_data), 64'd0);
            xfer(2'd3);
        end
        chk("busy_hold", 64'(busy), 64'd1);
        check_hold(1'b0, 1'b0, 64'h3FFFFFFFFFFFF);

        // Tile 2: only pixel 24 = 1; a sample offered during HOLD must be ignored
        for (int i = 0; i < 25; i++) xfer((i == 24) ? 2'd1 : 2'd0);
        chk("filt_kept", 64'(filt_data), 64'h0E4E4);
        check_hold(1'b0, 1'b1, 64'h1000000000000);
`ifdef CONV_LOADER_OVF_EN
        chk("ovf_set", 64'(ovf), 64'd1);
`endif

        // Tile 3: valid toggles, junk data in the gaps
        for (int i = 0; i < 25; i++) begin
            if (i > 0) begin
                s_if.s_data = 2'(~(i % 4));
                tick();
            end
            if (i == 24) chk("win_held_prev", 64'(win_data), 64'h1000000000000);
            xfer(2'(i % 4));
        end
        check_hold(1'b1, 1'b0, 64'h0E4E4E4E4E4E4);

        // Reload: all-ones weights go to the filter
        for (int i = 0; i < 9; i++) xfer(2'd1);
        chk("filt2", 64'(filt_data), 64'h15555);
        chk("win_after_reload", 64'(win_data), 64'h0E4E4E4E4E4E4);
`ifdef CONV_LOADER_OVF_EN
        chk("ovf_sticky", 64'(ovf), 64'd1);
`endif

        // Reset after 12 pixels
        for (int i = 0; i < 12; i++) xfer(2'd3);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_win", 64'(win_data), 64'd0);
        chk("mid_rst_filt", 64'(filt_data), 64'd0);
        chk("mid_rst_valid", 64'(win_valid), 64'd0);
        chk("mid_rst_ready", 64'(s_if.s_ready), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
`ifdef CONV_LOADER_OVF_EN
        chk("mid_rst_ovf", 64'(ovf), 64'd0);
`endif
        tick();
        rst_n = 1'b1;
        chk("rel_idle_ready", 64'(s_if.s_ready), 64'd0);
        chk("rel_idle_busy", 64'(busy), 64'd0);
        tick();
        chk("rel_loadf_ready", 64'(s_if.s_ready), 64'd1);
        chk("rel_loadf_busy", 64'(busy), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_window_loader.md
Name: conv_window_loader

Overview:
- Upstream feeder for the 3x3 convolution array.
- Accepts a serial stream of 2-bit samples over a valid/ready handshake: 9 filter weights, then 25 image pixels of a 5x5 tile.
- Packs them into the flat parallel words the convolution array consumes: 18-bit filter and 50-bit window.
- Holds each window stable and flags it valid for a programmable number of cycles so the MAC pipeline can capture it. The filter is retained across tiles until a reload is requested.

Parameters:
- PIX_W, 2, bits per pixel/weight.
- IMG, 5, tile edge in pixels; window = IMG*IMG elements.
- K, 3, filter edge; filter = K*K elements.
- HOLD_CYCLES, 4, cycles win_valid stays high per tile (>=1).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  upstream sample valid.
- s_ready  out  1  loader can accept a sample.
- s_data  in  PIX_W  sample (weight or pixel).
- filt_reload  in  1  request a new filter after the current tile.
- win_data  out  IMG*IMG*PIX_W (50)  packed window to the convolution array.
- filt_data  out  K*K*PIX_W (18)  packed filter to the convolution array.
- win_valid  out  1  win_data valid for the MAC stage.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset, asynchronous on rst_n low:
  - state=IDLE; counters 0.
  - win_data=0, filt_data=0, both shadow registers 0.
  - win_valid=0, s_ready=0, busy=0.
- States: IDLE, LOAD_F, LOAD_P, HOLD.
- IDLE -> LOAD_F unconditionally on the first clock after reset release.
- Transfer occurs when s_valid && s_ready.
- s_ready is decoded from state: 1 in LOAD_F and LOAD_P, 0 in IDLE and HOLD.
- LOAD_F:
  - Transfer n (n=0..8) writes s_data into filter shadow bits [2n+1:2n]; element index n = K*row+col.
  - On transfer n=8: filt_data <= shadow with that last weight merged, counter clears, -> LOAD_P.
- LOAD_P:
  - Transfer n (n=0..24) writes window shadow bits [2n+1:2n]; element index n = IMG*row+col, row-major, bit 0 = top-left.
  - On transfer n=24: win_data <= full shadow including that pixel (same edge), counter clears, -> HOLD.
- HOLD:
  - win_valid=1 for exactly HOLD_CYCLES cycles, starting the cycle after the last pixel transfer.
  - On the final HOLD cycle: win_valid drops next edge. If filt_reload=1 on that cycle -> LOAD_F, else -> LOAD_P.
  - filt_reload is sampled only on the final HOLD cycle; it is ignored elsewhere.
- win_data and filt_data change only on the final transfer of their load phase. They are stable throughout HOLD and throughout subsequent loading.
- A new window is first visible one cycle before win_valid rises.
- s_valid with s_ready=0: no transfer, no state change, data ignored.
- Idle gaps (s_valid=0) mid-load: counter holds, shadow holds.
- Reset mid-load or mid-HOLD: partial shadow discarded, outputs cleared, restart at IDLE.
- busy=1 in LOAD_F, LOAD_P and HOLD.

Optional Feature:
- Macro: CONV_LOADER_OVF_EN.
- Defined:
  - Adds output ovf (1 bit), reset 0, sticky.
  - ovf sets when s_valid=1 in a cycle where s_ready=0 and rst_n=1.
  - Cleared only by reset.
- Undefined: port absent, no overflow logic; behaviour otherwise identical.

Test Plan:
- Reset, then weights 0,1,2,3,0,1,2,3,0 back-to-back -> filt_data=18'h0E4E4 on the cycle after the 9th transfer; s_ready=1 throughout; state LOAD_P.
- After the filter, 25 pixels all 3 -> win_data=50'h3FFFFFFFFFFFF one cycle after the 25th transfer; win_valid high exactly 4 cycles; s_ready=0 for those 4 cycles.
- Second tile, pixel 24=1 and all others 0, filt_reload=0 -> win_data=50'h1000000000000; filt_data unchanged at 18'h0E4E4; the loader skips LOAD_F.
- Pixels with s_valid toggling 1,0,1,0… -> exactly 25 transfers accepted; win_valid timing relative to the last transfer unchanged; win_data holds the previous tile until then.
- filt_reload=1 on the final HOLD cycle, then weights all 1 -> s_ready stays high, the next 9 transfers go to the filter, filt_data=18'h15555.
- rst_n low after 12 pixels, release -> all outputs 0, IDLE then LOAD_F; with CONV_LOADER_OVF_EN, s_valid=1 during HOLD sets ovf=1 until reset.
